// File: rtl/chan_reload_streamer.sv
// Coefficient-reload writes -> gap-free AXI-Stream reload frames; optional config beat per frame (CHAN_RELOAD_CONFIG_EN).
// First word on tvalid 2 cycles after the last word's update edge; tready low holds the head, while pushes are never stalled and drop on full.

module chan_reload_fifo #(
  parameter int AW = 6,
  parameter int W  = 33
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);
  localparam int DEPTH = 1 << AW;

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW:0]  r_rd_ptr;
  logic [AW:0]  w_count;

  // Extra pointer bit makes count reach DEPTH, so full is simply its MSB.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = w_count[AW];
  assign o_empty = (w_count == '0);
  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !o_full) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop && !o_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

module chan_reload_streamer #(
  parameter int FIFO_AW = 6,
  parameter int DATA_W  = 32
) (
  input  logic              user_clk,
  input  logic              user_rstn,
  input  logic [DATA_W-1:0] cfg_reload_data,
  input  logic              cfg_reload_update,
  input  logic              cfg_reload_last,
  input  logic              cfg_chan_reset,
  output logic [DATA_W-1:0] m_axis_reload_tdata,
  output logic              m_axis_reload_tvalid,
  output logic              m_axis_reload_tlast,
  input  logic              m_axis_reload_tready,
  output logic [7:0]        m_axis_config_tdata,
  output logic              m_axis_config_tvalid,
  input  logic              m_axis_config_tready,
  output logic              status_reload_overflow,
  output logic              status_reload_busy,
  output logic [15:0]       status_frames_done
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM
`ifdef CHAN_RELOAD_CONFIG_EN
    , S_CONFIG
`endif
  } state_t;

  localparam logic [FIFO_AW:0] PEND_ONE = 1;

  state_t           r_state;
  logic             r_upd_q;
  logic             r_overflow;
  logic [FIFO_AW:0] r_frames_pending;
  logic [15:0]      r_frames_done;

  logic [DATA_W:0]  w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push_req;
  logic             w_push;
  logic             w_pop;
  logic             w_tlast_hs;

  assign w_push_req = cfg_reload_update & ~r_upd_q & ~cfg_chan_reset;
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = m_axis_reload_tvalid & m_axis_reload_tready;
  assign w_tlast_hs = w_pop & w_head[DATA_W];

  chan_reload_fifo #(.AW(FIFO_AW), .W(DATA_W + 1)) u_fifo (
    .i_clk   (user_clk),
    .i_rst_n (user_rstn),
    .i_flush (cfg_chan_reset),
    .i_push  (w_push),
    .i_dat   ({cfg_reload_last, cfg_reload_data}),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // STREAM is only entered with a complete frame queued, so the head is always valid there.
  assign m_axis_reload_tvalid   = (r_state == S_STREAM);
  assign m_axis_reload_tdata    = m_axis_reload_tvalid ? w_head[DATA_W-1:0] : '0;
  assign m_axis_reload_tlast    = m_axis_reload_tvalid & w_head[DATA_W];
  assign m_axis_config_tdata    = 8'h00;
  assign status_reload_overflow = r_overflow;
  assign status_reload_busy     = (r_state != S_IDLE) | ~w_empty;
  assign status_frames_done     = r_frames_done;

`ifdef CHAN_RELOAD_CONFIG_EN
  assign m_axis_config_tvalid = (r_state == S_CONFIG);
`else
  logic w_unused_cfg_tready;
  assign w_unused_cfg_tready  = m_axis_config_tready;
  assign m_axis_config_tvalid = 1'b0;
`endif

  always_ff @(posedge user_clk or negedge user_rstn) begin
    if (!user_rstn) begin
      r_state          <= S_IDLE;
      r_upd_q          <= 1'b0;
      r_overflow       <= 1'b0;
      r_frames_pending <= '0;
      r_frames_done    <= '0;
    end else begin
      r_upd_q <= cfg_reload_update;
      if (w_tlast_hs) r_frames_done <= r_frames_done + 16'd1;
      if (cfg_chan_reset) begin
        r_state          <= S_IDLE;
        r_overflow       <= 1'b0;
        r_frames_pending <= '0;
      end else begin
        if (w_push_req && w_full) r_overflow <= 1'b1;
        case ({w_push & cfg_reload_last, w_tlast_hs})
          2'b10:   r_frames_pending <= r_frames_pending + PEND_ONE;
          2'b01:   r_frames_pending <= r_frames_pending - PEND_ONE;
          default: r_frames_pending <= r_frames_pending;
        endcase
        case (r_state)
          S_IDLE:   if (r_frames_pending != '0) r_state <= S_STREAM;
`ifdef CHAN_RELOAD_CONFIG_EN
          S_STREAM: if (w_tlast_hs) r_state <= S_CONFIG;
          S_CONFIG: if (m_axis_config_tready) r_state <= S_IDLE;
`else
          S_STREAM: if (w_tlast_hs) r_state <= S_IDLE;
`endif
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_chan_reload_streamer.sv
// Directed bench: main instance (FIFO_AW=6) plus a FIFO_AW=2 instance for the overflow case.
module tb_chan_reload_streamer;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] cfg_reload_data = '0;
  logic        cfg_reload_update = 1'b0;
  logic        cfg_reload_last = 1'b0;
  logic        cfg_chan_reset = 1'b0;
  logic        rl_tready = 1'b0;
  logic        cf_tready = 1'b1;

  logic [31:0] rl_tdata;
  logic        rl_tvalid, rl_tlast, cf_tvalid, ovf, busy;
  logic [7:0]  cf_tdata;
  logic [15:0] fdone;

  logic [31:0] sm_tdata;
  logic        sm_tvalid, sm_tlast, sm_cf_tvalid, sm_ovf, sm_busy;
  logic [7:0]  sm_cf_tdata;
  logic [15:0] sm_fdone;

  int n_checks = 0;
  int n_fail = 0;
  int sm_tv_cnt = 0;
  logic [33:0] ev_q [$];
  logic [33:0] exp_q [$];
  localparam logic [33:0] CFG_EV = {1'b1, 1'b0, 32'h0};

  always #5 clk = ~clk;

  chan_reload_streamer #(.FIFO_AW(6), .DATA_W(32)) dut (
    .user_clk(clk), .user_rstn(rstn),
    .cfg_reload_data(cfg_reload_data), .cfg_reload_update(cfg_reload_update),
    .cfg_reload_last(cfg_reload_last), .cfg_chan_reset(cfg_chan_reset),
    .m_axis_reload_tdata(rl_tdata), .m_axis_reload_tvalid(rl_tvalid),
    .m_axis_reload_tlast(rl_tlast), .m_axis_reload_tready(rl_tready),
    .m_axis_config_tdata(cf_tdata), .m_axis_config_tvalid(cf_tvalid),
    .m_axis_config_tready(cf_tready),
    .status_reload_overflow(ovf), .status_reload_busy(busy), .status_frames_done(fdone)
  );

  chan_reload_streamer #(.FIFO_AW(2), .DATA_W(32)) dut_sm (
    .user_clk(clk), .user_rstn(rstn),
    .cfg_reload_data(cfg_reload_data), .cfg_reload_update(cfg_reload_update),
    .cfg_reload_last(cfg_reload_last), .cfg_chan_reset(cfg_chan_reset),
    .m_axis_reload_tdata(sm_tdata), .m_axis_reload_tvalid(sm_tvalid),
    .m_axis_reload_tlast(sm_tlast), .m_axis_reload_tready(rl_tready),
    .m_axis_config_tdata(sm_cf_tdata), .m_axis_config_tvalid(sm_cf_tvalid),
    .m_axis_config_tready(cf_tready),
    .status_reload_overflow(sm_ovf), .status_reload_busy(sm_busy), .status_frames_done(sm_fdone)
  );

  always @(negedge clk) begin
    if (rl_tvalid && rl_tready) ev_q.push_back({1'b0, rl_tlast, rl_tdata});
    if (cf_tvalid && cf_tready) ev_q.push_back(CFG_EV);
    if (sm_tvalid) sm_tv_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic l, output logic tv_mid);
    cfg_reload_data = d;
    cfg_reload_last = l;
    cfg_reload_update = 1'b1;
    tick();
    tv_mid = rl_tvalid;
    cfg_reload_update = 1'b0;
    tick();
  endtask

  task automatic chan_flush();
    cfg_chan_reset = 1'b1;
    tick();
    cfg_chan_reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] z = '0;
    n_checks++; if (rl_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid got %b want 0", rl_tvalid); end
    n_checks++; if (rl_tdata !== z) begin n_fail++; $display("FAIL rst_tdata got %h want 0", rl_tdata); end
    n_checks++; if (rl_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast got %b want 0", rl_tlast); end
    n_checks++; if (cf_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_tvalid got %b want 0", cf_tvalid); end
    n_checks++; if (cf_tdata !== 8'h00) begin n_fail++; $display("FAIL rst_cfg_tdata got %h want 00", cf_tdata); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", ovf); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (fdone !== 16'd0) begin n_fail++; $display("FAIL rst_frames_done got %0d want 0", fdone); end
    rstn = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_basic();
    logic tv;
    logic [31:0] w [4];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    chan_flush();
    rl_tready = 1'b1;
    cf_tready = 1'b1;
    push(w[0], 1'b0, tv);
    push(w[1], 1'b0, tv);
    push(w[2], 1'b0, tv);
    push(w[3], 1'b1, tv);
    n_checks++; if (tv !== 1'b0) begin n_fail++; $display("FAIL basic_tvalid_edge1 got %b want 0", tv); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (rl_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_tvalid[%0d] got %b want 1", i, rl_tvalid); end
      n_checks++; if (rl_tdata !== w[i]) begin n_fail++; $display("FAIL basic_tdata[%0d] got %h want %h", i, rl_tdata, w[i]); end
      n_checks++; if (rl_tlast !== (i == 3)) begin n_fail++; $display("FAIL basic_tlast[%0d] got %b want %b", i, rl_tlast, (i == 3)); end
      tick();
    end
`ifdef CHAN_RELOAD_CONFIG_EN
    n_checks++; if (cf_tvalid !== 1'b1) begin n_fail++; $display("FAIL basic_cfg_tvalid got %b want 1", cf_tvalid); end
    n_checks++; if (cf_tdata !== 8'h00) begin n_fail++; $display("FAIL basic_cfg_tdata got %h want 00", cf_tdata); end
    n_checks++; if (fdone !== 16'd1) begin n_fail++; $display("FAIL basic_frames_done got %0d want 1", fdone); end
    tick();
    n_checks++; if (cf_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_cfg_single got %b want 0", cf_tvalid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
`else
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nocfg_busy_after_tlast got %b want 0", busy); end
    n_checks++; if (fdone !== 16'd1) begin n_fail++; $display("FAIL basic_frames_done got %0d want 1", fdone); end
    tick();
    n_checks++; if (ev_q.size() != 4) begin n_fail++; $display("FAIL nocfg_event_count got %0d want 4 (no config beats)", ev_q.size()); end
`endif
  endtask

  task automatic test_backpressure();
    logic tv, stall;
    logic [31:0] pd;
    logic pl;
    chan_flush();
    rl_tready = 1'b0;
    push(32'h11, 1'b0, tv);
    push(32'h22, 1'b0, tv);
    push(32'h33, 1'b0, tv);
    push(32'h44, 1'b1, tv);
    ev_q.delete();
    stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (stall) begin
        n_checks++;
        if (rl_tvalid !== 1'b1 || rl_tdata !== pd || rl_tlast !== pl) begin
          n_fail++; $display("FAIL bp_hold cyc %0d got v=%b d=%h l=%b want v=1 d=%h l=%b", c, rl_tvalid, rl_tdata, rl_tlast, pd, pl);
        end
      end
      rl_tready = c[0];
      stall = rl_tvalid & ~rl_tready;
      pd = rl_tdata;
      pl = rl_tlast;
      tick();
    end
    rl_tready = 1'b1;
    exp_q.delete();
    exp_q.push_back({2'b00, 32'h11}); exp_q.push_back({2'b00, 32'h22});
    exp_q.push_back({2'b00, 32'h33}); exp_q.push_back({2'b01, 32'h44});
`ifdef CHAN_RELOAD_CONFIG_EN
    exp_q.push_back(CFG_EV);
`endif
    n_checks++; if (ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count got %0d want %0d", ev_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++; if (ev_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_event[%0d] got %h want %h", i, ev_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    logic tv;
    chan_flush();
    rl_tready = 1'b1;
    sm_tv_cnt = 0;
    for (int i = 0; i < 4; i++) push(32'h100 + i, 1'b0, tv);
    n_checks++; if (sm_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full got %b want 0", sm_ovf); end
    push(32'h104, 1'b0, tv);
    n_checks++; if (sm_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", sm_ovf); end
    n_checks++; if (sm_busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy got %b want 1", sm_busy); end
    tick();
    n_checks++; if (sm_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", sm_ovf); end
    chan_flush();
    n_checks++; if (sm_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared got %b want 0", sm_ovf); end
    n_checks++; if (sm_busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy_cleared got %b want 0", sm_busy); end
    n_checks++; if (sm_tv_cnt != 0) begin n_fail++; $display("FAIL ovf_no_output got %0d valid cycles want 0", sm_tv_cnt); end
    push(32'h5A, 1'b1, tv);
    n_checks++; if (sm_tvalid !== 1'b1 || sm_tdata !== 32'h5A || sm_tlast !== 1'b1) begin
      n_fail++; $display("FAIL ovf_recover got v=%b d=%h l=%b want v=1 d=5a l=1", sm_tvalid, sm_tdata, sm_tlast);
    end
    tick();
    tick();
  endtask

  task automatic test_two_frames();
    logic tv;
    logic [15:0] f0;
    chan_flush();
    rl_tready = 1'b0;
    f0 = fdone;
    ev_q.delete();
    push(32'hA1, 1'b0, tv);
    push(32'hA2, 1'b1, tv);
    push(32'hB1, 1'b0, tv);
    push(32'hB2, 1'b0, tv);
    push(32'hB3, 1'b1, tv);
    rl_tready = 1'b1;
    for (int c = 0; c < 20; c++) tick();
    exp_q.delete();
    exp_q.push_back({2'b00, 32'hA1}); exp_q.push_back({2'b01, 32'hA2});
`ifdef CHAN_RELOAD_CONFIG_EN
    exp_q.push_back(CFG_EV);
`endif
    exp_q.push_back({2'b00, 32'hB1}); exp_q.push_back({2'b00, 32'hB2}); exp_q.push_back({2'b01, 32'hB3});
`ifdef CHAN_RELOAD_CONFIG_EN
    exp_q.push_back(CFG_EV);
`endif
    n_checks++; if (ev_q.size() != exp_q.size()) begin n_fail++; $display("FAIL two_count got %0d want %0d", ev_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      n_checks++; if (ev_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL two_event[%0d] got %h want %h", i, ev_q[i], exp_q[i]); end
    end
    n_checks++; if (fdone - f0 !== 16'd2) begin n_fail++; $display("FAIL two_frames_done delta got %0d want 2", fdone - f0); end
  endtask

  task automatic test_reset_mid();
    logic tv;
    chan_flush();
    rl_tready = 1'b0;
    push(32'hC1, 1'b0, tv);
    push(32'hC2, 1'b0, tv);
    push(32'hC3, 1'b0, tv);
    push(32'hC4, 1'b1, tv);
    ev_q.delete();
    rl_tready = 1'b1;
    tick();
    tick();
    n_checks++; if (rl_tdata !== 32'hC3) begin n_fail++; $display("FAIL mid_word3 got %h want c3", rl_tdata); end
    rstn = 1'b0;
    #1;
    n_checks++; if (rl_tvalid !== 1'b0 || rl_tdata !== 32'h0 || rl_tlast !== 1'b0) begin
      n_fail++; $display("FAIL mid_drop got v=%b d=%h l=%b want all 0", rl_tvalid, rl_tdata, rl_tlast);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0 || ovf !== 1'b0 || fdone !== 16'd0 || cf_tvalid !== 1'b0 || rl_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL mid_after_release got busy=%b ovf=%b fd=%0d cfv=%b v=%b want all 0", busy, ovf, fdone, cf_tvalid, rl_tvalid);
    end
    n_checks++; if (ev_q.size() != 2) begin n_fail++; $display("FAIL mid_partial got %0d beats want 2", ev_q.size()); end
    push(32'hAB, 1'b1, tv);
    n_checks++; if (rl_tvalid !== 1'b1 || rl_tdata !== 32'hAB || rl_tlast !== 1'b1) begin
      n_fail++; $display("FAIL mid_new_frame got v=%b d=%h l=%b want v=1 d=ab l=1", rl_tvalid, rl_tdata, rl_tlast);
    end
    tick();
    n_checks++; if (fdone !== 16'd1) begin n_fail++; $display("FAIL mid_frames_done got %0d want 1", fdone); end
    tick();
    tick();
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_two_frames();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
